// File: rtl/core_pkg.sv
// Shared encodings for the write-back stage.
//   wb_sel_e : write-back source select (ALU, load data, PC+4, immediate)
//   F3_*     : load-format funct3 encodings understood by the load path
//   state_e  : write-back FSM state encoding
package core_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_e;

endpackage

// File: rtl/writeback_unit_if.sv
// Load handshake between the write-back stage and data memory.
//   mem_req    : one-cycle load request pulse (write-back -> memory)
//   mem_rvalid : load data valid            (memory -> write-back)
//   mem_rdata  : aligned data word          (memory -> write-back)
// The load address is the ALU result, which memory takes from the datapath.
interface writeback_unit_if #(
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/load_extend.sv
// Combinational load formatter.
//   word    in  : aligned data word from memory
//   addr_lo in  : low two address bits selecting the byte/half lane
//   funct3  in  : load format (LB, LH, LW, LBU, LHU)
//   data    out : selected lane, sign- or zero-extended to DATA_W
//   legal   out : funct3 is a known load format and the address is aligned
module load_extend
    import core_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] data,
    output logic              legal
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every output of an always_comb gets a default before any branch,
    // otherwise an uncovered path holds its old value and infers a latch.
    always_comb begin
        byte_lane = word[7:0];
        case (addr_lo)
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            2'd3:    byte_lane = word[31:24];
            default: byte_lane = word[7:0];
        endcase
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data  = word;
        legal = 1'b0;
        case (funct3)
            F3_LB: begin
                data  = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
                legal = 1'b1;
            end
            F3_LBU: begin
                data  = {{(DATA_W-8){1'b0}}, byte_lane};
                legal = 1'b1;
            end
            F3_LH: begin
                data  = {{(DATA_W-16){half_lane[15]}}, half_lane};
                legal = ~addr_lo[0];
            end
            F3_LHU: begin
                data  = {{(DATA_W-16){1'b0}}, half_lane};
                legal = ~addr_lo[0];
            end
            F3_LW: begin
                data  = word;
                legal = (addr_lo == 2'b00);
            end
            default: begin
                data  = word;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: drives the register-file write port.
//   clk, reset          : clock and synchronous active-high reset
//   instr_valid         : instruction presented this cycle
//   reg_write_en, rd    : instruction writes register rd
//   wb_sel              : source select (ALU, MEM, PC+4, IMM)
//   funct3              : load format
//   alu_result          : ALU output, also the load address
//   pc_plus4, imm       : link value and LUI immediate
//   mem                 : load handshake with data memory (master side)
//   stall               : hold PC/fetch while a load is outstanding (combinational)
//   load_err            : one-cycle pulse on misaligned/illegal load or timeout
//   RegWrite, Rd,
//   Write_data          : registered register-file write port
module writeback_unit
    import core_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic                  reg_write_en,
    input  logic [REG_AW-1:0]     rd,
    input  logic [1:0]            wb_sel,
    input  logic [2:0]            funct3,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     pc_plus4,
    input  logic [DATA_W-1:0]     imm,
    writeback_unit_if.master      mem,
    output logic                  stall,
    output logic                  load_err,
    output logic                  RegWrite,
    output logic [REG_AW-1:0]     Rd,
    output logic [DATA_W-1:0]     Write_data
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e              state;
    logic [CNT_W-1:0]    wait_cnt;

    // Fields of the outstanding load, captured at issue.
    logic [REG_AW-1:0]   cap_rd;
    logic                cap_we;
    logic [2:0]          cap_funct3;
    logic [1:0]          cap_addr_lo;

    logic [DATA_W-1:0]   wb_src;
    logic [DATA_W-1:0]   ext_data;
    logic                ext_legal;
    logic [2:0]          ext_funct3;
    logic [1:0]          ext_addr_lo;
    logic                is_load;
    logic                issue;

    // One formatter serves both phases: in IDLE it judges legality of the
    // incoming load, in WAIT_MEM it formats the returned word.
    assign ext_funct3  = (state == WAIT_MEM) ? cap_funct3  : funct3;
    assign ext_addr_lo = (state == WAIT_MEM) ? cap_addr_lo : alu_result[1:0];

    load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .word    (mem.mem_rdata),
        .addr_lo (ext_addr_lo),
        .funct3  (ext_funct3),
        .data    (ext_data),
        .legal   (ext_legal)
    );

    assign is_load = instr_valid && (wb_sel == WB_MEM);
    assign issue   = !reset && (state == IDLE) && is_load && ext_legal;

    // The request and stall must be seen in the issue cycle, so both are
    // combinational; stall falls in the cycle the response arrives.
    assign mem.mem_req = issue;
    assign stall       = issue ||
                         (!reset && (state == WAIT_MEM) && !mem.mem_rvalid);

    always_comb begin
        wb_src = alu_result;
        case (wb_sel)
            WB_PC4:  wb_src = pc_plus4;
            WB_IMM:  wb_src = imm;
            default: wb_src = alu_result;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            RegWrite   <= 1'b0;
            Rd         <= '0;
            Write_data <= '0;
            load_err   <= 1'b0;
        end else begin
            RegWrite <= 1'b0;
            load_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        if (!is_load) begin
                            // Rd/Write_data only move on a real write.
                            if (reg_write_en && (rd != '0)) begin
                                RegWrite   <= 1'b1;
                                Rd         <= rd;
                                Write_data <= wb_src;
                            end
                        end else if (ext_legal) begin
                            state       <= WAIT_MEM;
                            wait_cnt    <= '0;
                            // NOTE: the captured fields are only read in
                            // WAIT_MEM, which is always entered through here,
                            // so they need no reset.
                            cap_rd      <= rd;
                            cap_we      <= reg_write_en;
                            cap_funct3  <= funct3;
                            cap_addr_lo <= alu_result[1:0];
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem.mem_rvalid) begin
                        state <= IDLE;
                        if (cap_we && (cap_rd != '0)) begin
                            RegWrite   <= 1'b1;
                            Rd         <= cap_rd;
                            Write_data <= ext_data;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        // MEM_TIMEOUT waiting cycles elapsed without data.
                        state    <= IDLE;
                        load_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
